// File: rtl/eth_phy_loopback.sv
// eth_phy_loopback: rebuilds the MAC beat stream from the PHY block stream for TX->RX loopback,
// with a periodic gearbox-style ready stall. Define ETH_PHY_LOOPBACK_ERR_CNT_EN to add err_cnt_o.
module eth_phy_loopback #(
    parameter  int DATA_W      = 16,
    parameter  int BLOCK_N     = 8,
    parameter  int GAP_BLOCKS  = 32,
    localparam int KEEP_W      = DATA_W / 8,
    localparam int LEN_W       = $clog2(KEEP_W + 1),
    localparam int BLOCK_LEN_W = $clog2(BLOCK_N + 1),
    localparam int BEATS       = BLOCK_N / KEEP_W,
    localparam int LANE0_CNT_N = (DATA_W == 64) ? 2 : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   phy_ready_o,
    input  logic                   phy_ctrl_v_i,
    input  logic [DATA_W-1:0]      phy_data_i,
    input  logic [LANE0_CNT_N-1:0] phy_start_i,
    input  logic                   phy_idle_i,
    input  logic                   phy_term_i,
    input  logic [BLOCK_LEN_W-1:0] phy_term_len_i,
    output logic                   mac_valid_o,
    output logic [DATA_W-1:0]      mac_data_o,
    output logic [LANE0_CNT_N-1:0] mac_start_o,
    output logic                   mac_term_o,
    output logic [LEN_W-1:0]       mac_len_o,
    output logic                   phy_cancel_o
`ifdef ETH_PHY_LOOPBACK_ERR_CNT_EN
    ,
    output logic [15:0]            err_cnt_o
`endif
);
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STALL_W = $clog2(BEATS + 1);
    localparam int BLK_W   = (GAP_BLOCKS > 1) ? $clog2(GAP_BLOCKS) : 1;

    typedef enum logic {S_IDLE, S_FRAME} state_t;

    state_t                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [STALL_W-1:0]       stall_q, stall_d;
    logic [BLK_W-1:0]         blk_cnt_q, blk_cnt_d;
    logic                     h_ctrl_q, h_ctrl_d, h_term_q, h_term_d, h_idle_q, h_idle_d;
    logic [LANE0_CNT_N-1:0]   h_start_q, h_start_d;
    logic [BLOCK_LEN_W-1:0]   h_tlen_q, h_tlen_d;
    logic                     valid_q, valid_d, term_q, term_d, cancel_q, cancel_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic [LANE0_CNT_N-1:0]   start_q, start_d;
    logic [LEN_W-1:0]         len_q, len_d;

    logic                     accept, first, last, e_ctrl, e_term, e_idle;
    logic                     is_start, is_idle, is_term, err_inc;
    logic [LANE0_CNT_N-1:0]   e_start;
    logic [BLOCK_LEN_W-1:0]   e_tlen;
    int                       rem;

    assign accept       = (stall_q == '0);
    assign phy_ready_o  = accept;
    assign mac_valid_o  = valid_q;
    assign mac_data_o   = data_q;
    assign mac_start_o  = start_q;
    assign mac_term_o   = term_q;
    assign mac_len_o    = len_q;
    assign phy_cancel_o = cancel_q;

    always_comb begin
        first    = (beat_q == '0);
        last     = (beat_q == BEAT_W'(BEATS - 1));
        // Block controls are only meaningful on beat 0; later beats reuse the held copy.
        e_ctrl   = first ? phy_ctrl_v_i   : h_ctrl_q;
        e_start  = first ? phy_start_i    : h_start_q;
        e_term   = first ? phy_term_i     : h_term_q;
        e_idle   = first ? phy_idle_i     : h_idle_q;
        e_tlen   = first ? phy_term_len_i : h_tlen_q;
        is_start = e_ctrl && (|e_start);
        // An idle block carries no payload, so a term flag alongside it is not honoured.
        is_idle  = e_ctrl && e_idle && !is_start;
        is_term  = e_ctrl && e_term && !is_start && !is_idle;
        rem      = int'(e_tlen) - int'(beat_q) * KEEP_W;

        state_d   = state_q;
        beat_d    = beat_q;
        h_ctrl_d  = h_ctrl_q;
        h_start_d = h_start_q;
        h_term_d  = h_term_q;
        h_idle_d  = h_idle_q;
        h_tlen_d  = h_tlen_q;
        valid_d   = 1'b0;
        data_d    = '0;
        start_d   = '0;
        term_d    = 1'b0;
        len_d     = '0;
        cancel_d  = 1'b0;
        err_inc   = 1'b0;

        if (accept) begin
            beat_d    = last ? '0 : beat_q + 1'b1;
            h_ctrl_d  = e_ctrl;
            h_start_d = e_start;
            h_term_d  = e_term;
            h_idle_d  = e_idle;
            h_tlen_d  = e_tlen;
            unique case (state_q)
                S_IDLE: begin
                    if (is_start) begin
                        valid_d = 1'b1;
                        len_d   = LEN_W'(KEEP_W);
                        start_d = first ? e_start : '0;
                        if (last) state_d = S_FRAME;
                    end else if (first && (!e_ctrl || is_term)) begin
                        err_inc = 1'b1;
                    end
                end
                S_FRAME: begin
                    if (!e_ctrl || is_start) begin
                        valid_d = 1'b1;
                        len_d   = LEN_W'(KEEP_W);
                        if (is_start && first) begin
                            start_d  = e_start;
                            cancel_d = 1'b1;
                            err_inc  = 1'b1;
                        end
                    end else if (is_term) begin
                        if (rem > KEEP_W) begin
                            valid_d = 1'b1;
                            len_d   = LEN_W'(KEEP_W);
                        end else if (first || rem > 0) begin
                            valid_d = 1'b1;
                            term_d  = 1'b1;
                            len_d   = (rem > 0) ? LEN_W'(rem) : '0;
                        end
                        if (last) state_d = S_IDLE;
                    end else begin
                        if (first) begin
                            cancel_d = 1'b1;
                            err_inc  = 1'b1;
                        end
                        if (last) state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            data_d = valid_d ? phy_data_i : '0;
        end
    end

    // The stall opens right after the block that brings the count to GAP_BLOCKS.
    always_comb begin
        stall_d   = stall_q;
        blk_cnt_d = blk_cnt_q;
        if (stall_q != '0) begin
            stall_d = stall_q - 1'b1;
        end else if (GAP_BLOCKS != 0 && last) begin
            if (blk_cnt_q == BLK_W'(GAP_BLOCKS - 1)) begin
                stall_d   = STALL_W'(BEATS);
                blk_cnt_d = '0;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            stall_q   <= '0;
            blk_cnt_q <= '0;
            h_ctrl_q  <= 1'b0;
            h_start_q <= '0;
            h_term_q  <= 1'b0;
            h_idle_q  <= 1'b0;
            h_tlen_q  <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            start_q   <= '0;
            term_q    <= 1'b0;
            len_q     <= '0;
            cancel_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            stall_q   <= stall_d;
            blk_cnt_q <= blk_cnt_d;
            h_ctrl_q  <= h_ctrl_d;
            h_start_q <= h_start_d;
            h_term_q  <= h_term_d;
            h_idle_q  <= h_idle_d;
            h_tlen_q  <= h_tlen_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            start_q   <= start_d;
            term_q    <= term_d;
            len_q     <= len_d;
            cancel_q  <= cancel_d;
        end
    end

`ifdef ETH_PHY_LOOPBACK_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err;
    assign unused_err = err_inc;
`endif

endmodule

// File: tb/tb_eth_phy_loopback.sv
// tb_eth_phy_loopback: directed scoreboard bench for eth_phy_loopback (DATA_W=16, BEATS=4, GAP_BLOCKS=2).
`timescale 1ns/1ps
module tb_eth_phy_loopback;
    localparam int W = 22;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        phy_ready_o, phy_ctrl_v_i, phy_idle_i, phy_term_i;
    logic [15:0] phy_data_i;
    logic [0:0]  phy_start_i;
    logic [3:0]  phy_term_len_i;
    logic        mac_valid_o, mac_term_o, phy_cancel_o;
    logic [15:0] mac_data_o;
    logic [0:0]  mac_start_o;
    logic [1:0]  mac_len_o;
`ifdef ETH_PHY_LOOPBACK_ERR_CNT_EN
    logic [15:0] err_cnt_o;
    logic [15:0] err_before;
`endif

    eth_phy_loopback #(.DATA_W(16), .BLOCK_N(8), .GAP_BLOCKS(2)) dut (
        .clk(clk),
        .reset(reset),
        .phy_ready_o(phy_ready_o),
        .phy_ctrl_v_i(phy_ctrl_v_i),
        .phy_data_i(phy_data_i),
        .phy_start_i(phy_start_i),
        .phy_idle_i(phy_idle_i),
        .phy_term_i(phy_term_i),
        .phy_term_len_i(phy_term_len_i),
        .mac_valid_o(mac_valid_o),
        .mac_data_o(mac_data_o),
        .mac_start_o(mac_start_o),
        .mac_term_o(mac_term_o),
        .mac_len_o(mac_len_o),
        .phy_cancel_o(phy_cancel_o)
`ifdef ETH_PHY_LOOPBACK_ERR_CNT_EN
        ,
        .err_cnt_o(err_cnt_o)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_got, mon_want;

    function automatic logic [W-1:0] ent(input logic v, input logic s, input logic t,
                                         input logic [1:0] l, input logic c, input logic [15:0] d);
        return {v, s, t, l, c, d};
    endfunction

    function automatic logic [22:0] out_vec();
        return {mac_valid_o, mac_start_o, mac_term_o, mac_len_o, phy_cancel_o, mac_data_o, phy_ready_o};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // scoreboard expectation helpers
    task automatic exp_full(input logic [15:0] d);    exp_q.push_back(ent(1, 0, 0, 2, 0, d)); endtask
    task automatic exp_start(input logic [15:0] d);   exp_q.push_back(ent(1, 1, 0, 2, 0, d)); endtask
    task automatic exp_restart(input logic [15:0] d); exp_q.push_back(ent(1, 1, 0, 2, 1, d)); endtask
    task automatic exp_cancel();                      exp_q.push_back(ent(0, 0, 0, 0, 1, 16'h0)); endtask
    task automatic exp_term(input logic [1:0] l, input logic [15:0] d);
        exp_q.push_back(ent(1, 0, 1, l, 0, d));
    endtask
    task automatic exp_run(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) exp_full(base + 16'(i));
    endtask

    // driver tasks: called and returning at posedge+1
    task automatic drive_beat(input logic c, input logic s, input logic t, input logic idl,
                              input logic [3:0] tl, input logic [15:0] d, output int waits);
        waits = 0;
        while (!phy_ready_o && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!phy_ready_o) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout got=0 want=1");
        end
        phy_ctrl_v_i   = c;
        phy_start_i    = s;
        phy_term_i     = t;
        phy_idle_i     = idl;
        phy_term_len_i = tl;
        phy_data_i     = d;
        @(posedge clk);
        #1;
    endtask

    // Controls are driven on beat 0 only; the DUT has to hold them for the block.
    task automatic send_block(input logic c, input logic s, input logic t, input logic idl,
                              input logic [3:0] tl, input logic [15:0] base, output int waits);
        int w;
        drive_beat(c, s, t, idl, tl, base, waits);
        for (int i = 1; i < 4; i++) drive_beat(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, base + 16'(i), w);
    endtask

    task automatic blk_start(input logic [15:0] base);
        int w; send_block(1, 1, 0, 0, 4'd0, base, w);
    endtask
    task automatic blk_data(input logic [15:0] base);
        int w; send_block(0, 0, 0, 0, 4'd0, base, w);
    endtask
    task automatic blk_term(input logic [3:0] tl, input logic [15:0] base);
        int w; send_block(1, 0, 1, 0, tl, base, w);
    endtask
    task automatic blk_idle(input logic [15:0] base);
        int w; send_block(1, 0, 0, 1, 4'd0, base, w);
    endtask

    // monitor: pops one expectation per presented beat or cancel
    always @(negedge clk) begin
        if (!reset && (mac_valid_o || phy_cancel_o)) begin
            mon_got = {mac_valid_o, mac_start_o, mac_term_o, mac_len_o, phy_cancel_o, mac_data_o};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat got=%h want=none", mon_got);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    miscompares++;
                    $display("FAIL beat got=%h want=%h", mon_got, mon_want);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int w[6];
        int wd;
        phy_ctrl_v_i = 0; phy_start_i = 0; phy_term_i = 0; phy_idle_i = 0;
        phy_term_len_i = 0; phy_data_i = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(out_vec()), 32'h1);
`ifdef ETH_PHY_LOOPBACK_ERR_CNT_EN
        check("reset_err_cnt", 32'(err_cnt_o), 32'h0);
`endif
        reset = 1'b0;

        // stall pattern: GAP_BLOCKS=2, six blocks, last one term_len=7
        exp_start(16'h5100); exp_run(16'h5101, 3);
        exp_run(16'h5200, 4); exp_run(16'h5300, 4); exp_run(16'h5400, 4); exp_run(16'h5500, 4);
        exp_run(16'h5600, 3); exp_term(2'd1, 16'h5603);
        send_block(1, 1, 0, 0, 4'd0, 16'h5100, w[0]);
        send_block(0, 0, 0, 0, 4'd0, 16'h5200, w[1]);
        send_block(0, 0, 0, 0, 4'd0, 16'h5300, w[2]);
        send_block(0, 0, 0, 0, 4'd0, 16'h5400, w[3]);
        send_block(0, 0, 0, 0, 4'd0, 16'h5500, w[4]);
        send_block(1, 0, 1, 0, 4'd7, 16'h5600, w[5]);
        check("stall_before_b1", 32'(w[0]), 32'd0);
        check("stall_before_b2", 32'(w[1]), 32'd0);
        check("stall_before_b3", 32'(w[2]), 32'd4);
        check("stall_before_b4", 32'(w[3]), 32'd0);
        check("stall_before_b5", 32'(w[4]), 32'd4);
        check("stall_before_b6", 32'(w[5]), 32'd0);

        // start, data, term_len=5
        exp_start(16'h1100); exp_run(16'h1101, 3); exp_run(16'h1200, 4);
        exp_full(16'h1300); exp_full(16'h1301); exp_term(2'd1, 16'h1302);
        blk_start(16'h1100); blk_data(16'h1200); blk_term(4'd5, 16'h1300);

        // term_len=4 and term_len=0
        exp_start(16'h2100); exp_run(16'h2101, 3); exp_full(16'h2200); exp_term(2'd2, 16'h2201);
        blk_start(16'h2100); blk_term(4'd4, 16'h2200);
        exp_start(16'h2300); exp_run(16'h2301, 3); exp_term(2'd0, 16'h2400);
        blk_start(16'h2300); blk_term(4'd0, 16'h2400);

        // start and term in one block: start wins; then term_len=2
        exp_start(16'h7100); exp_run(16'h7101, 3); exp_term(2'd2, 16'h7200);
        send_block(1, 1, 1, 0, 4'd3, 16'h7100, wd);
        blk_term(4'd2, 16'h7200);

        // idle without term cancels; stray data/term then produce nothing
        exp_start(16'h3100); exp_run(16'h3101, 3); exp_run(16'h3200, 4); exp_cancel();
        blk_start(16'h3100); blk_data(16'h3200);
`ifdef ETH_PHY_LOOPBACK_ERR_CNT_EN
        err_before = err_cnt_o;
`endif
        blk_idle(16'h3300);
`ifdef ETH_PHY_LOOPBACK_ERR_CNT_EN
        check("err_cnt_missing_term", 32'(err_cnt_o), 32'(err_before) + 32'd1);
`endif
        blk_data(16'h3400); blk_term(4'd3, 16'h3500); blk_idle(16'h3550);
        // empty control block in a frame also cancels
        exp_start(16'h3600); exp_run(16'h3601, 3); exp_cancel();
        blk_start(16'h3600);
        send_block(1, 0, 0, 0, 4'd0, 16'h3700, wd);

        // restart inside a frame
        exp_start(16'h4100); exp_run(16'h4101, 3); exp_run(16'h4200, 4);
        exp_restart(16'h4300); exp_run(16'h4301, 3); exp_full(16'h4400); exp_term(2'd1, 16'h4401);
        blk_start(16'h4100); blk_data(16'h4200); blk_start(16'h4300); blk_term(4'd3, 16'h4400);

        // reset at beat 2 of a data block
        exp_start(16'h6100); exp_run(16'h6101, 3); exp_full(16'h6200); exp_full(16'h6201);
        blk_start(16'h6100);
        drive_beat(0, 0, 0, 0, 4'd0, 16'h6200, wd);
        drive_beat(0, 0, 0, 0, 4'd0, 16'h6201, wd);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset_async_clear", 32'(out_vec()), 32'h1);
        @(posedge clk);
        #1;
        check("reset_hold_clear", 32'(out_vec()), 32'h1);
        reset = 1'b0;
        exp_start(16'h6300); exp_run(16'h6301, 3); exp_term(2'd1, 16'h6400);
        blk_start(16'h6300); blk_term(4'd1, 16'h6400);

        blk_idle(16'h0); blk_idle(16'h0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
